// File: rtl/tt_um_weighted_majority_pkg.sv
// Shared constants for the recency-weighted majority trend detector.
package tt_um_weighted_majority_pkg;

  localparam int DEFAULT_WINDOW = 8;
  localparam int SCORE_W        = 6;

  localparam int TREND_BIT = 0;
  localparam int SCORE_LSB = 1;
  localparam int VALID_BIT = 7;

  // Half of the total weight 1+2+...+window.
  function automatic int thresh(input int window);
    return (window * (window + 1)) / 4;
  endfunction

endpackage

// File: rtl/tt_um_weighted_majority_weighted_sum.sv
// Combinational recency-weighted popcount: bit i of the history carries weight i+1.
module weighted_sum
  import tt_um_weighted_majority_pkg::*;
#(
  parameter int WINDOW = DEFAULT_WINDOW
) (
  input  logic [WINDOW-1:0]  hist,
  output logic [SCORE_W-1:0] score
);

  logic [SCORE_W-1:0] sum_s;

  // Accumulate the weights of all set history bits.
  always_comb begin
    sum_s = {SCORE_W{1'b0}};
    for (int i = 0; i < WINDOW; i++) begin
      if (hist[i]) begin
        sum_s = sum_s + SCORE_W'(i + 1);
      end else begin
        sum_s = sum_s;
      end
    end
  end

  assign score = sum_s;

endmodule

// File: rtl/tt_um_weighted_majority.sv
// Streaming trend detector: weighted sliding window over ui_in[0], registered
// trend/score/valid on uo_out, uio pins unused.
module tt_um_weighted_majority
  import tt_um_weighted_majority_pkg::*;
#(
  parameter int WINDOW = DEFAULT_WINDOW
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int                 CNT_W    = $clog2(WINDOW + 1);
  localparam logic [SCORE_W-1:0] THRESH   = SCORE_W'(thresh(WINDOW));
  localparam logic [CNT_W-1:0]   FILL_MAX = CNT_W'(WINDOW);

  logic [WINDOW-1:0]  hist_q,  hist_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               trend_q, trend_d;
  logic [CNT_W-1:0]   fill_q,  fill_d;
  logic               valid_q, valid_d;
  logic [SCORE_W-1:0] score_next_s;
  logic               unused_s;

  // Score is taken from the history that already includes this edge's sample.
  weighted_sum #(
    .WINDOW (WINDOW)
  ) u_weighted_sum (
    .hist  (hist_d),
    .score (score_next_s)
  );

  // Next-state: shift in the new sample, update trend with tie-hold, fill count.
  always_comb begin
    hist_d  = hist_q;
    score_d = score_q;
    trend_d = trend_q;
    fill_d  = fill_q;
    valid_d = valid_q;
    if (ena) begin
      hist_d  = {ui_in[0], hist_q[WINDOW-1:1]};
      score_d = score_next_s;
      if (score_next_s > THRESH) begin
        trend_d = 1'b1;
      end else if (score_next_s < THRESH) begin
        trend_d = 1'b0;
      end else begin
        trend_d = trend_q;
      end
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + CNT_W'(1);
      end else begin
        fill_d = fill_q;
      end
      valid_d = (fill_d == FILL_MAX);
    end else begin
      hist_d = hist_q;
    end
  end

  // State registers; reset port is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      hist_q  <= {WINDOW{1'b0}};
      score_q <= {SCORE_W{1'b0}};
      trend_q <= 1'b0;
      fill_q  <= {CNT_W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      score_q <= score_d;
      trend_q <= trend_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
    end
  end

  // Pin map: valid on bit 7, score on 6:1, trend on bit 0.
  always_comb begin
    uo_out                            = 8'h00;
    uo_out[TREND_BIT]                 = trend_q;
    uo_out[SCORE_LSB +: SCORE_W]      = score_q;
    uo_out[VALID_BIT]                 = valid_q;
  end

  assign uio_out  = 8'h00;
  assign uio_oe   = 8'h00;
  assign unused_s = ^{ui_in[7:1], uio_in};

endmodule

// File: tb/tb_tt_um_weighted_majority.sv
// Directed-vector bench for tt_um_weighted_majority with hand-computed expectations.
module tb_tt_um_weighted_majority;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_vec;
  int n_err;

  tt_um_weighted_majority dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Present one sample with ena=1 and sample outputs 1 time unit after the edge.
  task automatic sample(input logic d);
    ui_in = {7'b0000000, d};
    ena   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string tag, input logic d, input int s, input logic t, input logic v);
    logic [5:0] s6;
    s6 = s[5:0];
    sample(d);
    chk(tag, uo_out, {v, s6, t});
  endtask

  task automatic async_reset();
    #3;
    rst_n = 1'b1;
    #1;
    chk("async_reset", uo_out, 8'h00);
    @(posedge clk);
    #1;
    chk("reset_held", uo_out, 8'h00);
    rst_n = 1'b0;
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst_n  = 1'b1;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'hA5;
    #12;
    chk("por_reset", uo_out, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    chk("uio_out", uio_out, 8'h00);
    chk("uio_oe", uio_oe, 8'h00);

    // Dirty the state, then reset mid-cycle.
    step_chk("pre1", 1'b1, 8, 1'b0, 1'b0);
    step_chk("pre2", 1'b1, 15, 1'b0, 1'b0);
    step_chk("pre3", 1'b1, 21, 1'b1, 1'b0);
    async_reset();

    // 4 zeros then 5 ones.
    for (int i = 0; i < 4; i++) step_chk("zeros", 1'b0, 0, 1'b0, 1'b0);
    step_chk("one1", 1'b1, 8, 1'b0, 1'b0);
    step_chk("one2", 1'b1, 15, 1'b0, 1'b0);
    step_chk("one3", 1'b1, 21, 1'b1, 1'b0);
    step_chk("one4", 1'b1, 26, 1'b1, 1'b1);
    step_chk("one5", 1'b1, 30, 1'b1, 1'b1);

    // 6 zeros.
    step_chk("dz1", 1'b0, 25, 1'b1, 1'b1);
    step_chk("dz2", 1'b0, 20, 1'b1, 1'b1);
    step_chk("dz3", 1'b0, 15, 1'b0, 1'b1);
    step_chk("dz4", 1'b0, 10, 1'b0, 1'b1);
    step_chk("dz5", 1'b0, 6, 1'b0, 1'b1);
    step_chk("dz6", 1'b0, 3, 1'b0, 1'b1);

    // Tie from trend=1: window 8,7,6 (21) then shift to 7,6,5 (18).
    step_chk("tz1", 1'b0, 1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step_chk("tz", 1'b0, 0, 1'b0, 1'b1);
    step_chk("t1a", 1'b1, 8, 1'b0, 1'b1);
    step_chk("t1b", 1'b1, 15, 1'b0, 1'b1);
    step_chk("t1c", 1'b1, 21, 1'b1, 1'b1);
    step_chk("tie_hold1", 1'b0, 18, 1'b1, 1'b1);

    // Tie from trend=0: build window with ones at weights 8,7,3.
    step_chk("u1", 1'b0, 15, 1'b0, 1'b1);
    step_chk("u2", 1'b0, 12, 1'b0, 1'b1);
    step_chk("u3", 1'b1, 17, 1'b0, 1'b1);
    step_chk("u4", 1'b0, 13, 1'b0, 1'b1);
    step_chk("u5", 1'b0, 9, 1'b0, 1'b1);
    step_chk("u6", 1'b0, 6, 1'b0, 1'b1);
    step_chk("u7", 1'b1, 12, 1'b0, 1'b1);
    step_chk("tie_hold0", 1'b1, 18, 1'b0, 1'b1);

    // ena=0 holds everything while ui_in toggles.
    for (int i = 0; i < 5; i++) begin
      ena   = 1'b0;
      ui_in = {7'b0000000, i[0] ^ 1'b1};
      @(posedge clk);
      #1;
      chk("ena_hold", uo_out, 8'hA4);
    end
    step_chk("resume", 1'b1, 23, 1'b1, 1'b1);

    // All ones saturates the score.
    for (int i = 0; i < 8; i++) sample(1'b1);
    chk("all_ones", uo_out, 8'hC9);
    sample(1'b1);
    chk("all_ones_sat", uo_out, 8'hC9);

    // Reset discards history; valid returns only after 8 fresh samples.
    async_reset();
    step_chk("rf1", 1'b1, 8, 1'b0, 1'b0);
    step_chk("rf2", 1'b1, 15, 1'b0, 1'b0);
    step_chk("rf3", 1'b1, 21, 1'b1, 1'b0);
    step_chk("rf4", 1'b1, 26, 1'b1, 1'b0);
    step_chk("rf5", 1'b1, 30, 1'b1, 1'b0);
    step_chk("rf6", 1'b1, 33, 1'b1, 1'b0);
    step_chk("rf7", 1'b1, 35, 1'b1, 1'b0);
    step_chk("rf8", 1'b1, 36, 1'b1, 1'b1);
    chk("rf8_word", uo_out, 8'hC9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tt_um_weighted_majority.md
Name: tt_um_weighted_majority

Overview:
- Streaming trend detector on a single serial bit (ui_in[0]).
- Keeps a sliding window of the last WINDOW samples and weights each one by its recency (newest sample has the highest weight).
- Outputs a registered trend bit, the weighted score and a window-filled flag.
- Sits as a standard user-project top behind the shared chip I/O wrapper; the bidirectional pins are unused.

Parameters:
- WINDOW, 8, number of samples in the window. Legal range 2..8, so the score fits uo_out[6:1].
- THRESH, WINDOW*(WINDOW+1)/4 (18 for WINDOW=8), half of the total weight. Compared as a strict majority.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-high. rst_n=1 forces reset; rst_n=0 is normal operation.
- ena  input  1  sample enable. State advances only when ena=1.
- ui_in  input  8  bit 0 = serial data sample; bits 7:1 are ignored.
- uo_out  output  8  bit 0 = trend; bits 6:1 = weighted score (unsigned); bit 7 = valid.
- uio_in  input  8  unused, ignored.
- uio_out  output  8  constant 0.
- uio_oe  output  8  constant 0 (all uio pins are inputs).

Behaviour:
- Reset (async, rst_n=1): history=0, score=0, trend=0, fill count=0, valid=0. Outputs go to 0 immediately, with no clock needed. Reset mid-stream discards all history.
- History: WINDOW-bit shift register. Position 0 is the oldest sample and position WINDOW-1 is the newest.
- On each rising clk with ena=1 and not in reset:
  - The history shifts toward the oldest position, the oldest sample drops out, and ui_in[0] enters as the newest.
  - The weight of position i is i+1. The newest sample has weight WINDOW (8); the oldest has weight 1.
  - score_next = sum of (i+1) over all set bits of the new history. Range 0..36 for WINDOW=8; 6-bit unsigned, no overflow possible.
  - Trend update, using score_next:
    - score_next > THRESH: trend=1.
    - score_next < THRESH: trend=0.
    - score_next == THRESH (tie): trend holds its previous value.
  - Fill counter increments and saturates at WINDOW. valid=1 once WINDOW samples have been taken since reset.
- Latency: score, trend and valid are registered and are computed from the window that includes the sample captured at the same edge. They are visible one clock after that sample is presented.
- ena=0: all state and outputs hold; ui_in is ignored.
- Trend and score are driven even when valid=0; the unfilled positions count as 0.
- No combinational path from any input to uo_out.

Decomposition:
- Shared package holds:
  - WINDOW default 8.
  - SCORE_W = 6.
  - THRESH function/constant.
  - Output bit-index constants: TREND_BIT=0, SCORE_LSB=1, VALID_BIT=7.
- One sub-module, weighted_sum: purely combinational. Takes the WINDOW-bit history and returns the SCORE_W-bit recency-weighted popcount (adder tree).
- The top holds the shift register, trend/tie-hold register, fill counter and pin mapping.

Test Plan:
- Reset: pulse rst_n=1 asynchronously mid-cycle -> uo_out=0x00 immediately. After release, uio_out=0 and uio_oe=0.
- Run of 4 zeros then 5 ones (ena=1), checking uo_out[6:1] (score) and uo_out[0] (trend) after each edge:
  - During the zeros: score=0, trend=0.
  - Ones 1..5: score 8, 15, 21, 26, 30.
  - Trend goes to 1 at the third one; valid=1 after the 8th sample.
- Continue with 6 zeros:
  - Score 25, 20, 15, 10, 6, 3.
  - Trend stays 1 for the first two zeros and returns to 0 on the third (score 15).
- Tie hold:
  - Trend=1 state; window ones at weights 8, 7, 3 (score 18) -> trend stays 1.
  - From trend=0, reach the same score-18 window -> trend stays 0.
- ena=0 for 5 cycles while toggling ui_in[0] -> score, trend and valid unchanged. Resume with ena=1 and continue correctly.
- All ones for 8+ cycles -> score=36, trend=1, valid=1, uo_out=0xC9. Then reset -> uo_out=0x00 and valid=0 until 8 new samples have been taken.
